// File: rtl/sop_share_engine_pipe.sv
// rtl/sop_share_engine_pipe.sv - runtime-programmable shared-product SOP engine, 2-stage valid/ready pipe
// Optional error monitor enabled by defining SOP_ERR_MON_EN.
module sop_share_engine_pipe #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int N_PROD = 6,
    parameter int ET     = 2,
    localparam int CFG_W = (2 * N_IN > N_PROD) ? 2 * N_IN : N_PROD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_addr,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_commit,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic             err_flag,
    output logic [15:0]      err_cnt
);

    localparam logic [7:0] CFG_END = 8'(N_PROD + N_OUT);

    // Shadow bank is written by cfg_we; active bank feeds the datapath.
    logic [N_PROD-1:0][N_IN-1:0]   shd_pos_q, shd_pos_d;
    logic [N_PROD-1:0][N_IN-1:0]   shd_neg_q, shd_neg_d;
    logic [N_OUT-1:0][N_PROD-1:0]  shd_act_q, shd_act_d;
    logic [N_PROD-1:0][N_IN-1:0]   atv_pos_q, atv_pos_d;
    logic [N_PROD-1:0][N_IN-1:0]   atv_neg_q, atv_neg_d;
    logic [N_OUT-1:0][N_PROD-1:0]  atv_act_q, atv_act_d;
    logic                          cfg_err_q, cfg_err_d;

    logic                          s1_v_q, s1_v_d;
    logic [N_PROD-1:0]             s1_prod_q, s1_prod_d;
    logic [N_OUT-1:0][N_PROD-1:0]  s1_act_q, s1_act_d;
    logic                          s2_v_q, s2_v_d;
    logic [N_OUT-1:0]              out_data_q, out_data_d;

    logic                          s2_adv;
    logic                          accept;
    logic [N_PROD-1:0]             prod_c;
    logic [N_OUT-1:0]              or_c;

    always_comb begin
        shd_pos_d = shd_pos_q;
        shd_neg_d = shd_neg_q;
        shd_act_d = shd_act_q;
        cfg_err_d = 1'b0;
        if (cfg_we) begin
            for (int p = 0; p < N_PROD; p++) begin
                if (cfg_addr == 8'(p)) begin
                    shd_pos_d[p] = cfg_data[N_IN-1:0];
                    shd_neg_d[p] = cfg_data[2*N_IN-1:N_IN];
                end
            end
            for (int o = 0; o < N_OUT; o++) begin
                if (cfg_addr == 8'(N_PROD + o)) begin
                    shd_act_d[o] = cfg_data[N_PROD-1:0];
                end
            end
            cfg_err_d = (cfg_addr >= CFG_END);
        end
        // Commit takes the registered shadow, so a same-cycle write lands only in the shadow.
        atv_pos_d = cfg_commit ? shd_pos_q : atv_pos_q;
        atv_neg_d = cfg_commit ? shd_neg_q : atv_neg_q;
        atv_act_d = cfg_commit ? shd_act_q : atv_act_q;
    end

    always_comb begin
        prod_c = '0;
        for (int p = 0; p < N_PROD; p++) begin
            prod_c[p] = (&(in_data | ~atv_pos_q[p])) & (&(~in_data | ~atv_neg_q[p]));
        end
        or_c = '0;
        for (int o = 0; o < N_OUT; o++) begin
            or_c[o] = |(s1_prod_q & s1_act_q[o]);
        end
    end

    always_comb begin
        s2_adv   = !s2_v_q | out_ready;
        in_ready = !s1_v_q | s2_adv;
        accept   = in_valid & in_ready;

        s1_v_d    = accept | (s1_v_q & !s2_adv);
        s1_prod_d = accept ? prod_c : s1_prod_q;
        s1_act_d  = accept ? atv_act_q : s1_act_q;

        s2_v_d     = s2_adv ? s1_v_q : s2_v_q;
        out_data_d = (s2_adv & s1_v_q) ? or_c : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_pos_q  <= '0;
            shd_neg_q  <= '0;
            shd_act_q  <= '0;
            atv_pos_q  <= '0;
            atv_neg_q  <= '0;
            atv_act_q  <= '0;
            cfg_err_q  <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_prod_q  <= '0;
            s1_act_q   <= '0;
            s2_v_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            shd_pos_q  <= shd_pos_d;
            shd_neg_q  <= shd_neg_d;
            shd_act_q  <= shd_act_d;
            atv_pos_q  <= atv_pos_d;
            atv_neg_q  <= atv_neg_d;
            atv_act_q  <= atv_act_d;
            cfg_err_q  <= cfg_err_d;
            s1_v_q     <= s1_v_d;
            s1_prod_q  <= s1_prod_d;
            s1_act_q   <= s1_act_d;
            s2_v_q     <= s2_v_d;
            out_data_q <= out_data_d;
        end
    end

    assign cfg_err   = cfg_err_q;
    assign out_valid = s2_v_q;
    assign out_data  = out_data_q;

`ifdef SOP_ERR_MON_EN
    localparam logic [31:0] ET_U = 32'(ET);

    // Inputs ride along with S1 so the exact reference lines up with the S2 result.
    logic [N_IN-1:0]   s1_in_q, s1_in_d;
    logic              err_flag_q, err_flag_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [N_IN/2-1:0] mon_a, mon_b, mon_abs;
    logic [N_OUT-1:0]  mon_exact, mon_dist;

    always_comb begin
        s1_in_d   = accept ? in_data : s1_in_q;
        mon_a     = s1_in_q[N_IN/2-1:0];
        mon_b     = s1_in_q[N_IN-1:N_IN/2];
        mon_abs   = (mon_a >= mon_b) ? (mon_a - mon_b) : (mon_b - mon_a);
        mon_exact = N_OUT'(mon_abs);
        mon_dist  = (or_c >= mon_exact) ? (or_c - mon_exact) : (mon_exact - or_c);
        err_flag_d = (s2_adv & s1_v_q) ? (32'(mon_dist) > ET_U) : err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (s2_v_q & out_ready & err_flag_q & (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_in_q    <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_in_q    <= s1_in_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
`else
    localparam int unused_et = ET;

    assign err_flag = 1'b0;
    assign err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_sop_share_engine_pipe.sv
// tb/tb_sop_share_engine_pipe.sv - self-checking bench for sop_share_engine_pipe
module tb_sop_share_engine_pipe;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int N_PROD = 6;
    localparam int CFG_W  = 8;
    localparam int N_CFG  = N_PROD + N_OUT;
`ifdef SOP_ERR_MON_EN
    localparam int TB_ET  = 0;
`else
    localparam int TB_ET  = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we, cfg_commit, cfg_err;
    logic [7:0]       cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic             in_valid, in_ready, out_valid, out_ready, err_flag;
    logic [N_IN-1:0]  in_data;
    logic [N_OUT-1:0] out_data;
    logic [15:0]      err_cnt;

    always #5 clk = ~clk;

    sop_share_engine_pipe #(.N_IN(N_IN), .N_OUT(N_OUT), .N_PROD(N_PROD), .ET(TB_ET)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_flag(err_flag), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [N_OUT-1:0] data;
        logic             err;
    } res_t;

    typedef struct {
        logic [N_IN-1:0]  x;
        logic [N_OUT-1:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;
    int m_cnt = 0;
    logic m_err_exp = 1'b0;
    logic [CFG_W-1:0] m_shd [N_CFG];
    logic [CFG_W-1:0] m_atv [N_CFG];
    res_t sb_q [$];
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a product fires when every required-true input is 1 and every required-false input is 0.
    function automatic res_t ref_res(input logic [N_IN-1:0] x);
        res_t r;
        logic [N_PROD-1:0] prods;
        logic [N_IN-1:0] pos, neg;
        int a, b, ex, d;
        for (int p = 0; p < N_PROD; p++) begin
            pos = m_atv[p][N_IN-1:0];
            neg = m_atv[p][2*N_IN-1:N_IN];
            prods[p] = ((x & pos) == pos) && ((~x & neg) == neg);
        end
        for (int o = 0; o < N_OUT; o++) begin
            r.data[o] = (prods & m_atv[N_PROD+o][N_PROD-1:0]) != '0;
        end
`ifdef SOP_ERR_MON_EN
        a  = int'(x) % (1 << (N_IN / 2));
        b  = int'(x) >> (N_IN / 2);
        ex = ((a > b) ? a - b : b - a) % (1 << N_OUT);
        d  = int'(r.data) - ex;
        if (d < 0) d = -d;
        r.err = d > TB_ET;
`else
        a = 0; b = 0; ex = 0; d = 0;
        r.err = 1'b0;
`endif
        return r;
    endfunction

    task automatic model_clear();
        sb_q.delete();
        foreach (m_shd[i]) begin
            m_shd[i] = '0;
            m_atv[i] = '0;
        end
        m_cnt = 0;
        m_err_exp = 1'b0;
    endtask

    // One clock: observe handshakes at the falling edge, then return 1 ns after the rising edge.
    task automatic cycle();
        res_t e;
        @(negedge clk);
        if (!rst) begin
            check("err_cnt", err_cnt, m_cnt);
            check("cfg_err", cfg_err, m_err_exp);
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_res(in_data));
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_err", err_flag, e.err);
                    if (e.err && m_cnt < 65535) m_cnt++;
                end
            end
            m_err_exp = cfg_we && (cfg_addr >= N_CFG);
            if (cfg_commit) m_atv = m_shd;
            if (cfg_we && cfg_addr < N_CFG) m_shd[cfg_addr] = cfg_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_in_ready", in_ready, 1);
        in_valid = 0; cfg_we = 0; cfg_commit = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [CFG_W-1:0] d);
        cfg_we = 1; cfg_addr = a; cfg_data = d;
        cycle();
        cfg_we = 0;
    endtask

    task automatic do_commit();
        cfg_commit = 1;
        cycle();
        cfg_commit = 0;
    endtask

    task automatic prog_t2();
        cfg_wr(8'd0, 8'h0D);
        cfg_wr(8'd1, 8'h0C);
        cfg_wr(8'd2, 8'h04);
        cfg_wr(8'd3, 8'h01);
        cfg_wr(8'd4, 8'h10);
        cfg_wr(8'd5, 8'h00);
        cfg_wr(8'd6, 8'h10);
        cfg_wr(8'd7, 8'h0F);
        do_commit();
    endtask

    task automatic send_one(input string name, input logic [N_IN-1:0] x, input logic [N_OUT-1:0] exp);
        int k;
        in_valid = 1; in_data = x; out_ready = 1;
        cycle();
        in_valid = 0;
        k = 0;
        while (!out_valid && k < 5) begin
            cycle();
            k++;
        end
        check({name, "_latency"}, k, 1);
        check(name, out_data, exp);
        cycle();
    endtask

    task automatic drain(input string name);
        in_valid = 0; out_ready = 1;
        repeat (6) cycle();
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0000, 2'b01};
        tbl[1] = '{4'b0101, 2'b10};
        tbl[2] = '{4'b0011, 2'b10};
        tbl[3] = '{4'b0100, 2'b11};
        tbl[4] = '{4'b1000, 2'b01};
        tbl[5] = '{4'b1111, 2'b10};
        tbl[6] = '{4'b0010, 2'b01};

        rst = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        model_clear();
        #1 rst = 1;
        #2;
        check("init_out_valid", out_valid, 0);
        check("init_out_data", out_data, 0);
        check("init_in_ready", in_ready, 1);
        check("init_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1 rst = 0;

        send_one("zero_bank", 4'b1010, 2'b00);

        // T2 configuration and table of hand-derived results
        prog_t2();
        foreach (tbl[i]) send_one("t2_table", tbl[i].x, tbl[i].exp);

        // T3 backpressure: two samples fill the pipe, the rest wait
        out_ready = 0; in_valid = 1; acc_cnt = 0;
        repeat (4) begin
            in_data = 4'($urandom);
            cycle();
        end
        check("t3_accepted", acc_cnt, 2);
        check("t3_out_valid", out_valid, 1);
        check("t3_front", out_data, sb_q[0].data);
        begin
            logic [N_OUT-1:0] hold;
            hold = out_data;
            in_valid = 0;
            cycle();
            check("t3_stable", out_data, hold);
        end
        drain("t3_drain");

        // T1 reset with two samples in flight
        prog_t2();
        out_ready = 0; in_valid = 1;
        in_data = 4'b0101; cycle();
        in_data = 4'b0100; cycle();
        do_reset();
        send_one("t1_bank_cleared", 4'b0101, 2'b00);

        // T4 constant-1 and contradictory-literal products
        cfg_wr(8'd0, 8'h00);
        cfg_wr(8'd6, 8'h01);
        cfg_wr(8'd7, 8'h00);
        do_commit();
        for (int x = 0; x < 16; x++) send_one("t4_const1", 4'(x), 2'b01);
        cfg_wr(8'd0, 8'h11);
        do_commit();
        for (int x = 0; x < 16; x++) send_one("t4_const0", 4'(x), 2'b00);

        // T5 reprogram while streaming, including a write in the commit cycle
        prog_t2();
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 24; i++) begin
            in_data = 4'($urandom);
            cfg_we = 0; cfg_commit = 0;
            if (i == 5)  begin cfg_we = 1; cfg_addr = 8'd6; cfg_data = 8'h20; end
            if (i == 6)  begin cfg_we = 1; cfg_addr = 8'd7; cfg_data = 8'h00; end
            if (i == 10) begin cfg_commit = 1; cfg_we = 1; cfg_addr = 8'd6; cfg_data = 8'h01; end
            if (i == 16) cfg_commit = 1;
            cycle();
        end
        cfg_we = 0; cfg_commit = 0;
        drain("t5_drain");
        prog_t2();
        cfg_wr(8'd200, 8'hFF);
        check("t5_bad_pulse", cfg_err, 1);
        cycle();
        check("t5_bad_clear", cfg_err, 0);
        cfg_wr(8'd8, 8'h00);
        check("t5_edge_bad", cfg_err, 1);
        do_commit();
        foreach (tbl[i]) send_one("t5_unchanged", tbl[i].x, tbl[i].exp);

        // Randomized traffic with config churn
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom % 4) != 0;
            out_ready  = ($urandom % 3) != 0;
            in_data    = 4'($urandom);
            cfg_we     = ($urandom % 16) == 0;
            cfg_addr   = 8'($urandom % 10);
            cfg_data   = 8'($urandom);
            cfg_commit = ($urandom % 20) == 0;
            cycle();
        end
        cfg_we = 0; cfg_commit = 0;
        drain("rand_drain");

`ifdef SOP_ERR_MON_EN
        // T6 monitor with ET=0 and saturation
        do_reset();
        prog_t2();
        out_ready = 0; in_valid = 1; in_data = 4'b0011;
        cycle();
        in_valid = 0;
        cycle();
        check("t6_out_data", out_data, 2);
        check("t6_err_flag", err_flag, 1);
        out_ready = 1;
        cycle();
        check("t6_err_cnt", err_cnt, 1);
        in_valid = 1; in_data = 4'b0011;
        repeat (65540) cycle();
        drain("t6_drain");
        check("t6_saturate", err_cnt, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
